// File: rtl/stage_retire_csb.sv
// Retire stage: commits ROB head entries in order and parks retired stores in a
// committed-store buffer that drains to the D-cache one store per cycle.
package stage_retire_csb_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int MEM_SIZE_W = 2;
  localparam int PHYS_TAG_W = 6;
  localparam int REG_IDX_W  = 5;
  localparam int ROB_IDX_W  = 5;
  localparam int GHR_W      = 8;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  complete;
    logic                  is_store;
    logic                  is_halt;
    logic                  is_branch;
    logic [ADDR_W-1:0]     pc;
    logic [REG_IDX_W-1:0]  arch_rd;
    logic [PHYS_TAG_W-1:0] phys_rd;
    logic [PHYS_TAG_W-1:0] prev_phys_rd;
    logic                  pred_taken;
    logic [ADDR_W-1:0]     pred_target;
    logic                  actual_taken;
    logic [ADDR_W-1:0]     actual_target;
    logic [GHR_W-1:0]      ghr;
  } rob_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_W-1:0]    pc;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    data;
    logic                 halt;
  } commit_packet_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [GHR_W-1:0]  ghr;
    logic              mispredict;
  } bp_train_req_t;
endpackage

module stage_retire_csb
  import stage_retire_csb_pkg::*;
#(
  parameter int RETIRE_WIDTH     = 3,
  parameter int STORES_PER_CYCLE = 2,
  parameter int CSB_DEPTH        = 4,
  parameter int PHYS_REGS        = 64,
  parameter int ARCH_REGS        = 32
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  rob_entry_t [RETIRE_WIDTH-1:0]                  head_entries,
  input  logic [RETIRE_WIDTH-1:0]                        head_valids,
  input  logic [RETIRE_WIDTH-1:0][ROB_IDX_W-1:0]         head_idxs,
  input  logic [PHYS_REGS-1:0][DATA_W-1:0]               regfile_entries,
  input  logic [STORES_PER_CYCLE-1:0]                    sq_head_valid,
  input  logic [STORES_PER_CYCLE-1:0][ADDR_W-1:0]        sq_head_addr,
  input  logic [STORES_PER_CYCLE-1:0][DATA_W-1:0]        sq_head_data,
  input  logic [STORES_PER_CYCLE-1:0][MEM_SIZE_W-1:0]    sq_head_size,
  output logic [$clog2(STORES_PER_CYCLE+1)-1:0]          sq_free_count,
  output logic                                           dcache_st_valid,
  output logic [ADDR_W-1:0]                              dcache_st_addr,
  output logic [DATA_W-1:0]                              dcache_st_data,
  output logic [MEM_SIZE_W-1:0]                          dcache_st_size,
  input  logic                                           dcache_st_ack,
  output logic [$clog2(CSB_DEPTH+1)-1:0]                 csb_count,
  output logic                                           csb_empty,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]              retire_count_out,
  output logic                                           mispredict,
  output logic [ROB_IDX_W-1:0]                           rob_mispred_idx,
  output logic [ADDR_W-1:0]                              branch_target_out,
  output bp_train_req_t                                  train_req_o,
  output logic [RETIRE_WIDTH-1:0]                        arch_write_enables,
  output logic [RETIRE_WIDTH-1:0][REG_IDX_W-1:0]         arch_write_addrs,
  output logic [RETIRE_WIDTH-1:0][PHYS_TAG_W-1:0]        arch_write_phys_regs,
  output logic [PHYS_REGS-1:0]                           free_mask,
  output logic [PHYS_REGS-1:0]                           freelist_restore_mask,
  output commit_packet_t [RETIRE_WIDTH-1:0]              committed_insts
);

  localparam int SQ_W  = $clog2(STORES_PER_CYCLE+1);
  localparam int RC_W  = $clog2(RETIRE_WIDTH+1);
  localparam int CNT_W = $clog2(CSB_DEPTH+1);
  localparam int PTR_W = $clog2(CSB_DEPTH);
  localparam logic [PHYS_REGS-1:0] MASK_INIT =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PHYS_REGS-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0]     csb_addr_q [CSB_DEPTH];
  logic [DATA_W-1:0]     csb_data_q [CSB_DEPTH];
  logic [MEM_SIZE_W-1:0] csb_size_q [CSB_DEPTH];
  logic [SQ_W-1:0]       push_n;
  logic                  pop;

  assign csb_count       = count_q;
  assign csb_empty       = (count_q == '0);
  assign dcache_st_valid = !csb_empty;
  assign dcache_st_addr  = csb_addr_q[head_q];
  assign dcache_st_data  = csb_data_q[head_q];
  assign dcache_st_size  = csb_size_q[head_q];
  assign pop             = dcache_st_valid && dcache_st_ack;
  assign count_d         = count_q + CNT_W'(push_n) - CNT_W'(pop);
  assign freelist_restore_mask = mask_d;

  // In-order walk; store space uses registered occupancy so a same-cycle drain never frees a slot.
  always_comb begin
    rob_entry_t                  e;
    logic                        stop, take, mis;
    int                          n_ret, n_st, space;
    logic [STORES_PER_CYCLE-1:0] sqv_rem;
    e = '0;
    stop = 1'b0;
    take = 1'b0;
    mis = 1'b0;
    n_ret = 0;
    n_st = 0;
    space = CSB_DEPTH - int'(count_q);
    sqv_rem = '0;
    mask_d = mask_q;
    free_mask = '0;
    mispredict = 1'b0;
    rob_mispred_idx = '0;
    branch_target_out = '0;
    train_req_o = '0;
    arch_write_enables = '0;
    arch_write_addrs = '0;
    arch_write_phys_regs = '0;
    committed_insts = '0;
    for (int w = 0; w < RETIRE_WIDTH; w++) begin
      e = head_entries[w];
      take = 1'b0;
      sqv_rem = sq_head_valid >> n_st;
      if (!stop) begin
        if (!head_valids[w] || !e.complete) begin
          stop = 1'b1;
        end else if (e.is_store) begin
          if (n_st < STORES_PER_CYCLE && sqv_rem[0] && n_st < space) begin
            take = 1'b1;
            n_st = n_st + 1;
          end else begin
            stop = 1'b1;
          end
        end else if (e.is_halt) begin
          take = csb_empty && (n_st == 0);
          stop = 1'b1;
        end else begin
          take = 1'b1;
        end
      end
      if (take) begin
        n_ret = n_ret + 1;
        committed_insts[w].valid = 1'b1;
        committed_insts[w].pc    = e.pc;
        committed_insts[w].halt  = e.is_halt;
        committed_insts[w].data  = regfile_entries[e.phys_rd];
        committed_insts[w].reg_idx = (e.phys_rd == '0) ? ZERO_REG : e.arch_rd;
        if (e.phys_rd != '0) begin
          arch_write_enables[w]   = 1'b1;
          arch_write_addrs[w]     = e.arch_rd;
          arch_write_phys_regs[w] = e.phys_rd;
          mask_d[e.phys_rd]       = 1'b0;
          if (e.prev_phys_rd != '0) begin
            free_mask[e.prev_phys_rd] = 1'b1;
            mask_d[e.prev_phys_rd]    = 1'b1;
          end
        end
        if (e.is_branch) begin
          mis = (e.actual_taken != e.pred_taken) ||
                (e.actual_taken && (e.actual_target != e.pred_target));
          branch_target_out      = e.actual_target;
          train_req_o.valid      = 1'b1;
          train_req_o.pc         = e.pc;
          train_req_o.taken      = e.actual_taken;
          train_req_o.target     = e.actual_target;
          train_req_o.ghr        = e.ghr;
          train_req_o.mispredict = mis;
          if (mis) begin
            mispredict      = 1'b1;
            rob_mispred_idx = head_idxs[w];
            stop            = 1'b1;
          end
        end
      end
    end
    retire_count_out = RC_W'(n_ret);
    push_n           = SQ_W'(n_st);
    sq_free_count    = SQ_W'(n_st);
  end

  // The k-th store retired this cycle is SQ entry k, so pushes land at tail+k in program order.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mask_q  <= MASK_INIT;
    end else begin
      for (int k = 0; k < STORES_PER_CYCLE; k++) begin
        if (k < int'(push_n)) begin
          csb_addr_q[tail_q + PTR_W'(k)] <= sq_head_addr[k];
          csb_data_q[tail_q + PTR_W'(k)] <= sq_head_data[k];
          csb_size_q[tail_q + PTR_W'(k)] <= sq_head_size[k];
        end
      end
      tail_q <= tail_q + PTR_W'(push_n);
      if (pop) head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

endmodule
